// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared types and tile geometry for the Canny tile sequencer
package canny_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam int TILE_DIM   = 20;
    localparam int OUT_DIM    = 18;
    localparam int TILE_BEATS = 80;
    localparam int BEAT_PIX   = 5;
    localparam int PIX_W      = 4;
    localparam int BEAT_W     = BEAT_PIX * PIX_W;

    localparam int GAUSS = 0;
    localparam int SOBEL = 1;
    localparam int NMS   = 2;
    localparam int HYST  = 3;

endpackage

// File: rtl/canny_raster_counter.sv
// rtl/canny_raster_counter.sv - row/col raster counter with enable, clear and last flag
module canny_raster_counter #(
    parameter int W  = 18,
    parameter int H  = 18,
    parameter int CW = 5,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (col_q == CW'(W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == RW'(H - 1)) && (col_q == CW'(W - 1));

endmodule

// File: rtl/canny_tile_sequencer.sv
// rtl/canny_tile_sequencer.sv - per-tile load / stage sequencing / output scan controller
module canny_tile_sequencer
    import canny_pkg::*;
#(
    parameter int LOAD_BEATS    = TILE_BEATS,
    parameter int OUT_W         = OUT_DIM,
    parameter int OUT_H         = OUT_DIM,
    parameter int N_STAGE       = 4,
    parameter int STAGE_TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               load_ready,
    output logic               buf_we,
    output logic [6:0]         buf_waddr,
    output logic               load_end,
    output logic [N_STAGE-1:0] stage_start,
    input  logic [N_STAGE-1:0] stage_done,
    input  logic               out_ready,
    output logic               readable,
    output logic [4:0]         out_row,
    output logic [4:0]         out_col,
    output logic               tile_done,
    output logic               timeout_err,
    output logic               overrun_err
);

    localparam int SW   = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
    localparam int WD_W = $clog2(STAGE_TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [6:0]      beat_q, beat_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic            started_q, started_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            load_end_q, load_end_d;
    logic            tile_done_q, tile_done_d;
    logic            timeout_q, timeout_d;
    logic            overrun_q, overrun_d;

    logic accept;
    logic scan_en;
    logic scan_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            stage_q     <= '0;
            started_q   <= 1'b0;
            wd_q        <= '0;
            load_end_q  <= 1'b0;
            tile_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            stage_q     <= stage_d;
            started_q   <= started_d;
            wd_q        <= wd_d;
            load_end_q  <= load_end_d;
            tile_done_q <= tile_done_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    // Within RUN, started_q low marks the single start-pulse cycle of the current stage.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        stage_d     = stage_q;
        started_d   = started_q;
        wd_d        = wd_q;
        load_end_d  = load_end_q;
        tile_done_d = 1'b0;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q | (in_valid & ~load_ready);
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    if (beat_q == 7'(LOAD_BEATS - 1)) begin
                        state_d    = RUN;
                        beat_d     = '0;
                        load_end_d = 1'b1;
                        stage_d    = '0;
                        started_d  = 1'b0;
                    end else begin
                        state_d = LOAD;
                        beat_d  = beat_q + 7'd1;
                    end
                end
            end
            RUN: begin
                if (!started_q) begin
                    started_d = 1'b1;
                    wd_d      = WD_W'(1);
                end else if (stage_done[stage_q] || (wd_q == WD_W'(STAGE_TIMEOUT))) begin
                    if (!stage_done[stage_q])
                        timeout_d = 1'b1;
                    started_d = 1'b0;
                    wd_d      = '0;
                    if (stage_q == SW'(N_STAGE - 1))
                        state_d = OUT;
                    else
                        stage_d = stage_q + SW'(1);
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            OUT: begin
                if (out_ready && scan_last) begin
                    state_d     = IDLE;
                    tile_done_d = 1'b1;
                    load_end_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready  = (state_q == IDLE) || (state_q == LOAD);
        accept      = in_valid && load_ready;
        buf_we      = accept;
        buf_waddr   = beat_q;
        load_end    = load_end_q;
        stage_start = '0;
        if (state_q == RUN && !started_q)
            stage_start = N_STAGE'(1) << stage_q;
        readable    = (state_q == OUT);
        scan_en     = (state_q == OUT) && out_ready;
        tile_done   = tile_done_q;
        timeout_err = timeout_q;
        overrun_err = overrun_q;
    end

    canny_raster_counter #(
        .W (OUT_W),
        .H (OUT_H),
        .CW(5),
        .RW(5)
    ) u_scan (
        .clk  (clk),
        .reset(reset),
        .clr  (state_q != OUT),
        .en   (scan_en),
        .row  (out_row),
        .col  (out_col),
        .last (scan_last)
    );

endmodule

// File: tb/tb_canny_tile_sequencer.sv
// tb/tb_canny_tile_sequencer.sv - randomized self-checking bench for canny_tile_sequencer
module tb_canny_tile_sequencer;

    localparam int T_OUT = 15;
    localparam int NB    = 80;
    localparam int OW    = 18;
    localparam int OH    = 18;
    localparam int NPIX  = OW * OH;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       load_ready;
    logic       buf_we;
    logic [6:0] buf_waddr;
    logic       load_end;
    logic [3:0] stage_start;
    logic [3:0] stage_done = 4'd0;
    logic       out_ready = 1'b0;
    logic       readable;
    logic [4:0] out_row;
    logic [4:0] out_col;
    logic       tile_done;
    logic       timeout_err;
    logic       overrun_err;

    int total = 0;
    int bad   = 0;
    bit exp_to  = 1'b0;
    bit exp_ovr = 1'b0;

    canny_tile_sequencer #(
        .LOAD_BEATS   (NB),
        .OUT_W        (OW),
        .OUT_H        (OH),
        .N_STAGE      (4),
        .STAGE_TIMEOUT(T_OUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .load_ready (load_ready),
        .buf_we     (buf_we),
        .buf_waddr  (buf_waddr),
        .load_end   (load_end),
        .stage_start(stage_start),
        .stage_done (stage_done),
        .out_ready  (out_ready),
        .readable   (readable),
        .out_row    (out_row),
        .out_col    (out_col),
        .tile_done  (tile_done),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".load_ready"}, load_ready, 1);
        check({tag, ".readable"}, readable, 0);
        check({tag, ".load_end"}, load_end, 0);
        check({tag, ".stage_start"}, stage_start, 0);
        check({tag, ".timeout_err"}, timeout_err, exp_to);
        check({tag, ".overrun_err"}, overrun_err, exp_ovr);
    endtask

    // stall: 0 none, 1 every 3rd cycle, 2 random; bp: 0 none, 1 toggle 1010, 2 random
    // dly: 0 done 10 cycles after start, else random 1..14; to_stage: stage that never answers
    task automatic run_tile(input int stall, input int bp, input int dly, input int to_stage,
                            input bit spurious, input int abort_row);
        int beats = 0;
        int cyc   = 0;
        int k     = 0;
        int rd_cycles = 0;
        bit iv, rdy;
        int d;
        while (beats < NB) begin
            @(negedge clk);
            iv = 1'b1;
            if (stall == 1 && (cyc % 3) == 2) iv = 1'b0;
            if (stall == 2 && $urandom_range(0, 3) == 0) iv = 1'b0;
            in_valid = iv; stage_done = 4'd0; out_ready = 1'($urandom_range(0, 1));
            #1;
            check("load.we", buf_we, iv);
            if (iv) begin
                check("load.addr", buf_waddr, beats);
                beats++;
            end
            check("load.ready", load_ready, 1);
            check("load.end_early", load_end, 0);
            check("load.tile_done", tile_done, 0);
            cyc++;
            if (cyc > 1000) begin
                check("load.budget", cyc, 0);
                return;
            end
        end
        for (int s = 0; s < 4; s++) begin
            d = (dly == 0) ? 10 : int'($urandom_range(1, 14));
            if (s == to_stage) d = T_OUT;
            for (int t = 0; t <= d; t++) begin
                @(negedge clk);
                in_valid = 1'b0; out_ready = 1'b0; stage_done = 4'd0;
                if (spurious && s == 0 && t == 0) stage_done = 4'b0001;
                if (spurious && s == 1 && t == 3) stage_done = 4'b1000;
                if (s != to_stage && t == d) stage_done = 4'(1 << s);
                #1;
                check($sformatf("run%0d.start_t%0d", s, t), stage_start, (t == 0) ? (1 << s) : 0);
                check("run.load_end", load_end, 1);
                check("run.load_ready", load_ready, 0);
                check("run.readable", readable, 0);
                if (t == 0) check($sformatf("run%0d.timeout_err", s), timeout_err, exp_to);
            end
            if (s == to_stage) exp_to = 1'b1;
        end
        cyc = 0;
        while (k < NPIX) begin
            @(negedge clk);
            rdy = 1'b1;
            if (bp == 1) rdy = ((cyc % 2) == 0);
            if (bp == 2) rdy = 1'($urandom_range(0, 1));
            in_valid = spurious && (cyc == 5);
            stage_done = 4'($urandom_range(0, 15));
            out_ready = rdy;
            if (abort_row >= 0 && k == abort_row * OW) reset = 1'b1;
            #1;
            rd_cycles += readable;
            check("out.readable", readable, 1);
            check("out.row", out_row, k / OW);
            check("out.col", out_col, k % OW);
            check("out.tile_done", tile_done, 0);
            check("out.load_end", load_end, 1);
            if (reset) begin
                @(negedge clk);
                reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stage_done = 4'd0;
                exp_to = 1'b0; exp_ovr = 1'b0;
                #1;
                check("abort.tile_done", tile_done, 0);
                check_idle("abort");
                @(negedge clk);
                #1;
                check("abort.tile_done2", tile_done, 0);
                return;
            end
            if (in_valid) exp_ovr = 1'b1;
            if (rdy) k++;
            cyc++;
            if (cyc > 4000) begin
                check("out.budget", cyc, 0);
                return;
            end
        end
        if (bp == 0) check("out.readable_cycles", rd_cycles, NPIX);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; stage_done = 4'd0;
        #1;
        check("end.tile_done", tile_done, 1);
        check_idle("end");
        check("end.row", out_row, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst.tile_done", tile_done, 0);
        check("rst.buf_we", buf_we, 0);
        check("rst.buf_waddr", buf_waddr, 0);
        check("rst.row", out_row, 0);
        check("rst.col", out_col, 0);
        check_idle("rst");

        run_tile(0, 0, 0, -1, 1'b0, -1);
        run_tile(1, 0, 0, -1, 1'b0, -1);
        run_tile(0, 1, 0, -1, 1'b0, -1);
        run_tile(0, 0, 0, 1, 1'b0, -1);
        run_tile(0, 0, 0, -1, 1'b1, -1);
        run_tile(0, 0, 0, -1, 1'b0, 9);
        run_tile(0, 0, 0, -1, 1'b0, -1);
        for (int i = 0; i < 4; i++)
            run_tile(2, 2, 1, (i == 2) ? int'($urandom_range(0, 3)) : -1, 1'(i & 1), -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/canny_tile_sequencer.md
Name: canny_tile_sequencer

Overview:
- Top-level controller for the CHIP Canny edge pipeline.
- Works one 20x20 input tile at a time:
  - counts 80 input beats of 5x4-bit pixels into the tile buffer;
  - runs the four filter stages in order with start/done handshakes: gaussian, sobel, nms, hysteresis;
  - streams the 18x18 = 324 edge-bit result with the readable qualifier.
- Replaces the ad-hoc load_end/readable glue currently living in CHIP.

Parameters:
- LOAD_BEATS, 80, input beats per tile (5 pixels each)
- OUT_W, 18, output columns per tile
- OUT_H, 18, output rows per tile
- N_STAGE, 4, number of sequenced filter stages
- STAGE_TIMEOUT, 1023, max cycles a stage may run before being flagged

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  host presents 5 pixels this cycle
- load_ready  out  1  controller accepts input beats
- buf_we  out  1  tile-buffer write enable
- buf_waddr  out  7  tile-buffer beat address, 0..LOAD_BEATS-1
- load_end  out  1  last input beat accepted; held until output phase ends
- stage_start  out  N_STAGE  one-hot, single-cycle start pulse
- stage_done  in  N_STAGE  stage completion pulses
- out_ready  in  1  consumer accepts the output bit this cycle
- readable  out  1  edge_out valid
- out_row  out  5  output row index, 0..OUT_H-1
- out_col  out  5  output column index, 0..OUT_W-1
- tile_done  out  1  single-cycle pulse after the last output bit
- timeout_err  out  1  sticky: a stage exceeded STAGE_TIMEOUT
- overrun_err  out  1  sticky: in_valid while load_ready low

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; all counters 0.
  - All outputs 0, except load_ready = 1.
  - Sticky error flags are cleared.
  - Reset asserted mid-tile aborts the tile immediately. No tile_done is produced. The next cycle is IDLE.
- IDLE:
  - load_ready = 1.
  - An in_valid beat goes to LOAD: buf_we = 1 and buf_waddr = 0 in the same cycle (combinational from in_valid and state), and the beat counter becomes 1.
- LOAD:
  - Each in_valid cycle: buf_we = 1, buf_waddr = beat count, count increments.
  - Cycles without in_valid are stall cycles: no write, count holds.
  - The beat at address LOAD_BEATS-1:
    - sets load_end (registered, visible the next cycle);
    - drops load_ready the next cycle;
    - transitions to RUN with stage index 0.
- RUN:
  - On entry, stage_start[k] pulses for exactly 1 cycle.
  - stage_done[k] is sampled only from the cycle after that start pulse; a done coincident with the start is ignored.
  - stage_done bits of non-active stages are ignored.
  - On stage_done[k]: if k < N_STAGE-1, pulse stage_start[k+1] the next cycle; otherwise go to OUT.
  - Minimum gap from done to the next start is 1 cycle.
- Stage watchdog:
  - A cycle counter runs per stage.
  - When it reaches STAGE_TIMEOUT: set timeout_err, force-advance as if done was received.
  - The sequencer never hangs.
- OUT:
  - readable = 1 while in OUT.
  - out_row/out_col start at 0,0.
  - On each cycle with out_ready = 1: col increments; col wraps at OUT_W-1 to 0 and row increments.
  - out_ready = 0 holds the indices; readable stays 1.
  - The handshake at (OUT_H-1, OUT_W-1):
    - pulse tile_done the next cycle;
    - clear load_end and readable;
    - return to IDLE with load_ready = 1.
  - The next tile can therefore begin 1 cycle after the final output handshake.
- overrun_err: set by in_valid while in RUN or OUT. The beat is dropped and has no other effect.
- All indices are unsigned and counters saturate-free. Widths are sized by the parameters: 7 bits covers 80 beats; 5 bits covers 18.

Decomposition:
- Shared package (canny_pkg), containing:
  - state enum: IDLE, LOAD, RUN, OUT;
  - tile geometry constants 20/18/80 and the 5-pixel beat width;
  - stage index constants: GAUSS = 0, SOBEL = 1, NMS = 2, HYST = 3.
- One natural sub-module: canny_raster_counter. It is a parameterised row/col counter with enable, wrap and last flag, used for the output scan.

Test Plan:
- Nominal tile:
  - stimulus: 80 consecutive in_valid beats; stage_done each 10 cycles after start; out_ready held 1.
  - required response:
    - buf_waddr runs 0..79;
    - load_end rises the cycle after beat 79;
    - stage_start pulses 0x1, 0x2, 0x4, 0x8 in order;
    - readable for exactly 324 cycles;
    - tile_done is 1 cycle, and load_ready is back the same cycle.
- Input stalls: in_valid low on every 3rd cycle -> exactly 80 writes, addresses contiguous 0..79, load_end after the 80th write only.
- Output backpressure: out_ready toggles 1010... -> 324 handshakes; indices hold on low cycles; last pair is (17,17); tile_done follows the 324th handshake.
- Stage timeout:
  - stimulus: STAGE_TIMEOUT = 15; the sobel stage never returns done.
  - required response: timeout_err set at 15 cycles; stage_start[2] pulses the next cycle; the tile still completes.
- Spurious and early handshakes:
  - stimulus: stage_done[3] during stage 1; stage_done[0] in the same cycle as stage_start[0]; in_valid during OUT.
  - required response: all done pulses ignored; overrun_err = 1; output count unaffected.
- Mid-tile reset:
  - stimulus: reset during OUT at row 9.
  - required response: the next cycle is IDLE, readable = 0, load_end = 0, errors cleared, no tile_done; a following full tile passes the nominal checks.
